// File: rtl/rect_plotter.sv
// Rasterises one axis-aligned rectangle per start request into a pixel stream
// (x, y, colour, plot) with pacing and off-screen clipping. Optional outline mode: RECT_PLOTTER_OUTLINE_EN.
module rect_plotter #(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int COLOUR_W = 3,
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter int PACE     = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    input  logic [X_W-1:0]      x0,
    input  logic [Y_W-1:0]      y0,
    input  logic [X_W-1:0]      w,
    input  logic [Y_W-1:0]      h,
    input  logic [COLOUR_W-1:0] colour_in,
`ifdef RECT_PLOTTER_OUTLINE_EN
    input  logic                outline,
`endif
    output logic [X_W-1:0]      x,
    output logic [Y_W-1:0]      y,
    output logic [COLOUR_W-1:0] colour,
    output logic                plot,
    output logic                busy,
    output logic                done
);

    localparam int PC_W = (PACE > 1) ? $clog2(PACE) : 1;

    typedef enum logic [1:0] {IDLE, DRAW, FIN} state_t;

    state_t              state_q, state_d;
    logic [X_W-1:0]      x0_q, x0_d, w_q, w_d, cx_q, cx_d, x_q, x_d;
    logic [Y_W-1:0]      y0_q, y0_d, h_q, h_d, cy_q, cy_d, y_q, y_d;
    logic [COLOUR_W-1:0] col_q, col_d, colour_q, colour_d;
    logic [PC_W-1:0]     pace_q, pace_d;
    logic                plot_q, plot_d, busy_q, busy_d, done_q, done_d;
    logic                ol_q, ol_d;
    logic                step_d, last_px, interior_row;
    logic [X_W-1:0]      cx_nxt;
    logic [Y_W-1:0]      cy_nxt;
    logic [X_W:0]        x_sum;
    logic [Y_W:0]        y_sum;

    always_comb begin
        state_d  = state_q;
        x0_d     = x0_q;
        y0_d     = y0_q;
        w_d      = w_q;
        h_d      = h_q;
        col_d    = col_q;
        ol_d     = ol_q;
        cx_d     = cx_q;
        cy_d     = cy_q;
        pace_d   = pace_q;
        step_d   = 1'b0;
        done_d   = 1'b0;

        last_px      = (cx_q == w_q - X_W'(1)) && (cy_q == h_q - Y_W'(1));
        interior_row = ol_q && (cy_q != '0) && (cy_q != h_q - Y_W'(1));
        cx_nxt       = cx_q + X_W'(1);
        cy_nxt       = cy_q;
        if (cx_q == w_q - X_W'(1)) begin
            cx_nxt = '0;
            cy_nxt = cy_q + Y_W'(1);
        end else if (interior_row && (cx_q == '0)) begin
            // Outline mode skips the interior of a row in a single step.
            cx_nxt = w_q - X_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    x0_d   = x0;
                    y0_d   = y0;
                    w_d    = w;
                    h_d    = h;
                    col_d  = colour_in;
`ifdef RECT_PLOTTER_OUTLINE_EN
                    ol_d   = outline;
`else
                    ol_d   = 1'b0;
`endif
                    cx_d   = '0;
                    cy_d   = '0;
                    pace_d = '0;
                    if ((w == '0) || (h == '0)) begin
                        state_d = FIN;
                        done_d  = 1'b1;
                    end else begin
                        state_d = DRAW;
                        step_d  = 1'b1;
                    end
                end
            end
            DRAW: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (pace_q == PC_W'(PACE - 1)) begin
                    pace_d = '0;
                    if (last_px) begin
                        state_d = FIN;
                        done_d  = 1'b1;
                    end else begin
                        cx_d   = cx_nxt;
                        cy_d   = cy_nxt;
                        step_d = 1'b1;
                    end
                end else begin
                    pace_d = pace_q + PC_W'(1);
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Sums carry one extra bit so coordinates past 2^W are clipped, never wrapped.
        x_sum    = {1'b0, x0_d} + {1'b0, cx_d};
        y_sum    = {1'b0, y0_d} + {1'b0, cy_d};
        x_d      = x_sum[X_W-1:0];
        y_d      = y_sum[Y_W-1:0];
        plot_d   = step_d && (x_sum < (X_W+1)'(SCREEN_W)) && (y_sum < (Y_W+1)'(SCREEN_H));
        busy_d   = (state_d == DRAW);
        colour_d = (state_d == DRAW) ? col_d : '0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            x0_q     <= '0;
            y0_q     <= '0;
            w_q      <= '0;
            h_q      <= '0;
            col_q    <= '0;
            ol_q     <= 1'b0;
            cx_q     <= '0;
            cy_q     <= '0;
            pace_q   <= '0;
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
            plot_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            x0_q     <= x0_d;
            y0_q     <= y0_d;
            w_q      <= w_d;
            h_q      <= h_d;
            col_q    <= col_d;
            ol_q     <= ol_d;
            cx_q     <= cx_d;
            cy_q     <= cy_d;
            pace_q   <= pace_d;
            x_q      <= x_d;
            y_q      <= y_d;
            colour_q <= colour_d;
            plot_q   <= plot_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign x      = x_q;
    assign y      = y_q;
    assign colour = colour_q;
    assign plot   = plot_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_rect_plotter.sv
// Bench for rect_plotter: a PACE=1 and a PACE=3 instance, a per-cycle expected
// stream built from the rectangle rules, and literal timing/count expectations.
module tb_rect_plotter;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start0 = 1'b0, start1 = 1'b0, abort_i = 1'b0;
    logic [7:0] x0_i = '0, w_i = '0;
    logic [6:0] y0_i = '0, h_i = '0;
    logic [2:0] col_i = '0;
    logic       ol_i = 1'b0;

    logic [7:0] xo0, xo1;
    logic [6:0] yo0, yo1;
    logic [2:0] co0, co1;
    logic       pl0, pl1, bs0, bs1, dn0, dn1;

    rect_plotter #(.PACE(1)) dut0 (
        .clk(clk), .reset(reset), .start(start0), .abort(abort_i),
        .x0(x0_i), .y0(y0_i), .w(w_i), .h(h_i), .colour_in(col_i),
`ifdef RECT_PLOTTER_OUTLINE_EN
        .outline(ol_i),
`endif
        .x(xo0), .y(yo0), .colour(co0), .plot(pl0), .busy(bs0), .done(dn0)
    );

    rect_plotter #(.PACE(3)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .abort(abort_i),
        .x0(x0_i), .y0(y0_i), .w(w_i), .h(h_i), .colour_in(col_i),
`ifdef RECT_PLOTTER_OUTLINE_EN
        .outline(ol_i),
`endif
        .x(xo1), .y(yo1), .colour(co1), .plot(pl1), .busy(bs1), .done(dn1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected word: {plot, busy, done, colour[2:0], x[7:0], y[6:0]}
    logic [20:0] exp0_q[$];
    logic [20:0] exp1_q[$];
    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;
    int pc[2], dc[2], first_c[2], last_c[2], done_c[2];
    int n_start;

    function automatic int qsize(input int inst);
        return (inst == 0) ? exp0_q.size() : exp1_q.size();
    endfunction

    function automatic void push_exp(input int inst, input logic [20:0] v);
        if (inst == 0) exp0_q.push_back(v);
        else exp1_q.push_back(v);
    endfunction

    function automatic logic [20:0] front_exp(input int inst);
        if (qsize(inst) == 0) return '0;
        return (inst == 0) ? exp0_q[0] : exp1_q[0];
    endfunction

    // Keep only the entry for the current cycle; everything after is cancelled.
    function automatic void truncate(input int inst);
        while (qsize(inst) > 1) begin
            if (inst == 0) void'(exp0_q.pop_back());
            else void'(exp1_q.pop_back());
        end
    endfunction

    // Cycle of acceptance is idle; then each stepped pixel fills pace cycles, then one done cycle.
    function automatic void build(input int inst, input int px, input int py, input int pw,
                                  input int ph, input int pace, input logic [2:0] col, input bit ol);
        int sx, sy;
        logic p;
        push_exp(inst, 21'd0);
        if (pw != 0 && ph != 0) begin
            for (int ry = 0; ry < ph; ry++) begin
                for (int rx = 0; rx < pw; rx++) begin
                    if (ol && pw > 1 && ph > 1 && ry > 0 && ry < ph - 1 && rx > 0 && rx < pw - 1)
                        continue;
                    sx = px + rx;
                    sy = py + ry;
                    p  = (sx < 160) && (sy < 120);
                    for (int k = 0; k < pace; k++)
                        push_exp(inst, {(k == 0) && p, 1'b1, 1'b0, col, sx[7:0], sy[6:0]});
                end
            end
        end
        push_exp(inst, {3'b001, 18'd0});
    endfunction

    task automatic check_inst(input int inst, input logic p, input logic b, input logic d,
                              input logic [2:0] c, input logic [7:0] xv, input logic [6:0] yv);
        logic [20:0] e;
        e = '0;
        if (inst == 0 && exp0_q.size() > 0) e = exp0_q.pop_front();
        if (inst == 1 && exp1_q.size() > 0) e = exp1_q.pop_front();
        checks++;
        if ({p, b, d, c} !== e[20:15]) begin
            errors++;
            $display("FAIL ctrl inst%0d cyc %0d: plot/busy/done/colour got %b%b%b/%0d need %b%b%b/%0d",
                     inst, cyc, p, b, d, c, e[20], e[19], e[18], e[17:15]);
        end
        if (e[20]) begin
            checks++;
            if (xv !== e[14:7] || yv !== e[6:0]) begin
                errors++;
                $display("FAIL pixel inst%0d cyc %0d: got (%0d,%0d) need (%0d,%0d)",
                         inst, cyc, xv, yv, e[14:7], e[6:0]);
            end
        end
        if (p === 1'b1) begin
            pc[inst]++;
            if (first_c[inst] < 0) first_c[inst] = cyc;
            last_c[inst] = cyc;
        end
        if (d === 1'b1) begin
            dc[inst]++;
            done_c[inst] = cyc;
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check_inst(0, pl0, bs0, dn0, co0, xo0, yo0);
            check_inst(1, pl1, bs1, dn1, co1, xo1, yo1);
        end
    end

    task automatic chk_int(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d need %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_stats(input int inst);
        pc[inst] = 0; dc[inst] = 0;
        first_c[inst] = -1; last_c[inst] = -1; done_c[inst] = -1;
    endtask

    task automatic press(input int inst);
        if (inst == 0) start0 = 1'b1;
        else start1 = 1'b1;
        if (qsize(inst) == 0)
            build(inst, int'(x0_i), int'(y0_i), int'(w_i), int'(h_i),
                  (inst == 0) ? 1 : 3, col_i, ol_i);
        step();
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic do_rect(input int inst, input int px, input int py, input int pw,
                           input int ph, input logic [2:0] col, input bit ol);
        x0_i = px[7:0]; y0_i = py[6:0]; w_i = pw[7:0]; h_i = ph[6:0];
        col_i = col; ol_i = ol;
        clear_stats(inst);
        n_start = cyc;
        press(inst);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((exp0_q.size() != 0 || exp1_q.size() != 0) && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL timeout: waited %0d cycles, need completion", n);
            exp0_q.delete();
            exp1_q.delete();
        end
    endtask

    task automatic do_abort();
        abort_i = 1'b1;
        for (int i = 0; i < 2; i++)
            if (front_exp(i)[19]) truncate(i);
        step();
        abort_i = 1'b0;
    endtask

    initial begin
        clear_stats(0);
        clear_stats(1);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);
        chk_int("reset x0", int'(xo0), 0);
        chk_int("reset y0", int'(yo0), 0);
        chk_int("reset outs1", int'({pl1, bs1, dn1, co1, xo1}), 0);
        step();

        // Top border
        do_rect(0, 15, 20, 126, 1, 3'd7, 1'b0);
        wait_idle(400);
        chk_int("border plots", pc[0], 126);
        chk_int("border first", first_c[0], n_start + 1);
        chk_int("border last", last_c[0], n_start + 126);
        chk_int("border done", done_c[0], n_start + 127);

        // Right-edge clip
        do_rect(0, 150, 105, 20, 2, 3'd2, 1'b0);
        wait_idle(200);
        chk_int("clip plots", pc[0], 20);
        chk_int("clip done", done_c[0], n_start + 41);

        // Sum past 255 must clip, not wrap
        do_rect(0, 250, 10, 10, 1, 3'd3, 1'b0);
        wait_idle(100);
        chk_int("wrap plots", pc[0], 0);
        chk_int("wrap done", done_c[0], n_start + 11);

        // Empty rectangles
        do_rect(0, 5, 5, 0, 4, 3'd1, 1'b0);
        wait_idle(20);
        chk_int("empty w plots", pc[0], 0);
        chk_int("empty w done", done_c[0], n_start + 1);
        do_rect(0, 5, 5, 3, 0, 3'd1, 1'b0);
        wait_idle(20);
        chk_int("empty h done", done_c[0], n_start + 1);

        // Second start while busy is ignored, operand changes are ignored
        do_rect(0, 40, 30, 4, 4, 3'd6, 1'b0);
        step();
        x0_i = 8'd3; w_i = 8'd9; col_i = 3'd1;
        press(0);
        wait_idle(100);
        chk_int("busy plots", pc[0], 16);
        chk_int("busy dones", dc[0], 1);
        chk_int("busy done", done_c[0], n_start + 17);

        // Abort during the 5th plot
        do_rect(0, 60, 60, 10, 10, 3'd4, 1'b0);
        repeat (4) step();
        do_abort();
        repeat (20) step();
        chk_int("abort plots", pc[0], 5);
        chk_int("abort dones", dc[0], 0);

        // Reset mid-draw
        do_rect(0, 60, 60, 10, 10, 3'd5, 1'b0);
        repeat (3) step();
        reset = 1'b0;
        truncate(0);
        truncate(1);
        step();
        reset = 1'b1;
        @(negedge clk);
        chk_int("mreset x", int'(xo0), 0);
        chk_int("mreset y", int'(yo0), 0);
        chk_int("mreset outs", int'({pl0, bs0, dn0, co0}), 0);
        step();
        repeat (10) step();
        chk_int("mreset plots", pc[0], 4);
        chk_int("mreset dones", dc[0], 0);

        // Pacing
        do_rect(1, 1, 2, 2, 2, 3'd5, 1'b0);
        wait_idle(100);
        chk_int("pace plots", pc[1], 4);
        chk_int("pace first", first_c[1], n_start + 1);
        chk_int("pace last", last_c[1], n_start + 10);
        chk_int("pace done", done_c[1], n_start + 13);

`ifdef RECT_PLOTTER_OUTLINE_EN
        do_rect(0, 10, 10, 4, 3, 3'd7, 1'b1);
        wait_idle(100);
        chk_int("outline plots", pc[0], 10);
        chk_int("outline done", done_c[0], n_start + 11);
`endif

        repeat (3) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
